alu_seq: RTL
============

Name: alu_seq

Overview:
- Next-generation datapath ALU for the accumulator CPU, parametrised in width and extended from 8 to 16 opcodes.
- Adds SUB, OR, shifts and an optional multi-cycle multiply.
- Registers result and flags behind a valid/ready handshake so the controller can stall on multi-cycle operations.
- Sits between the accumulator/memory-data path and the accumulator write-back.

Parameters:
- WIDTH, 8, operand and result width in bits (min 2).
- CNT_W, $clog2(WIDTH+1), multiply iteration counter width (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands and opcode valid
- in_ready  out  1  block can accept an operation this cycle
- in_a  in  WIDTH  operand A (accumulator)
- in_b  in  WIDTH  operand B (memory data)
- opcode  in  4  operation select
- out_valid  out  1  result slot holds a valid result
- out_ready  in  1  consumer takes the result this cycle
- alu_out  out  WIDTH  registered result
- carry  out  1  registered carry/borrow/shift-out/overflow flag
- zero  out  1  registered, 1 when alu_out == 0
- a_is_zero  out  1  registered, 1 when captured in_a == 0

Behaviour:
- Opcode map, all results truncated to WIDTH:
  - 0000, 0001, 0110, 0111, 1101, 1110, 1111: pass in_a
  - 0010: in_a + in_b
  - 0011: in_a & in_b
  - 0100: in_a ^ in_b
  - 0101: pass in_b
  - 1000: in_a - in_b
  - 1001: in_a | in_b
  - 1010: in_a << 1
  - 1011: in_a >> 1 (logical)
  - 1100: MUL, low WIDTH bits of in_a*in_b
- carry rules:
  - ADD: carry-out.
  - SUB: borrow, 1 iff in_a < in_b unsigned.
  - SHL: old MSB. SHR: old LSB.
  - MUL: 1 iff upper WIDTH bits of the full product are nonzero.
  - All other opcodes: 0.
- Accept: transfer occurs when in_valid && in_ready at a rising edge. in_valid is ignored while in_ready=0.
- in_ready = (state==IDLE) && (!out_valid || out_ready). The slot may be refilled in the same cycle it drains.
- State machine:
  - IDLE, single-cycle opcode accepted: result and flags loaded, out_valid=1 next cycle (latency 1). Stay IDLE.
  - IDLE, MUL accepted: go to BUSY and load operands; the shift-add iteration counter starts at 0.
  - BUSY: one iteration per cycle; in_ready=0. After WIDTH iterations, load result/flags, set out_valid, return to IDLE.
  - MUL result latency is exactly WIDTH+1 cycles after the accept edge.
- Output slot:
  - out_valid stays high with alu_out/carry/zero/a_is_zero stable until out_ready=1.
  - out_valid && out_ready with no new accept: out_valid clears next cycle; data holds last value.
  - Simultaneous drain and accept: the new result replaces the old with no bubble.
- Reset:
  - state=IDLE, out_valid=0, alu_out=0, carry=0, zero=0, a_is_zero=0, counter=0.
  - rst mid-MUL aborts the operation; no result is produced.
  - rst has priority over all handshakes.
- Arithmetic is unsigned only.
- The operand path has no combinational dependency on out_ready beyond in_ready.

Optional Feature:
- Macro ALU_MUL_EN.
- Defined: opcode 1100 is the multi-cycle MUL described above; the BUSY state and multiplier are instantiated.
- Undefined: opcode 1100 is a single-cycle pass of in_a with carry=0; the BUSY state is unreachable and the multiplier logic is absent. in_ready reduces to !out_valid || out_ready.

Decomposition:
- Shared package alu_pkg:
  - 4-bit opcode localparams (OP_HLT, OP_SKZ, OP_ADD, OP_AND, OP_XOR, OP_LDA, OP_STO, OP_JMP, OP_SUB, OP_OR, OP_SHL, OP_SHR, OP_MUL).
  - State encoding (ST_IDLE, ST_BUSY).
- Sub-module alu_mul_seq (only under ALU_MUL_EN):
  - Shift-add multiplier with start/done, WIDTH-cycle iteration and a 2*WIDTH product.
  - alu_seq owns the handshake and the result slot.

Test Plan:
- WIDTH=8. ADD a=0xF0, b=0x20, out_ready=1 -> next cycle out_valid=1, alu_out=0x10, carry=1, zero=0.
- SUB a=0x05, b=0x05, then SUB a=0x03, b=0x05 -> first 0x00 zero=1 carry=0; second 0xFE carry=1.
- Back-pressure: accept XOR 0xAA^0xFF with out_ready=0 for 3 cycles -> alu_out=0x55 held, in_ready=0, a second in_valid is not accepted. out_ready=1 with new OR -> drained and refilled with no bubble.
- MUL a=0x12, b=0x10 (ALU_MUL_EN) -> in_ready=0 for 8 cycles, out_valid at cycle 9 after accept, alu_out=0x20, carry=1 (product 0x0120).
- rst asserted on cycle 4 of a MUL -> next cycle out_valid=0, alu_out=0, in_ready=1, no late result appears.
- Without ALU_MUL_EN: opcode 1100, a=0x00, b=0x33 -> latency 1, alu_out=0x00, zero=1, a_is_zero=1, carry=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential accumulator ALU: opcode map and
// controller state encoding, imported by alu_seq and its interface users.
package alu_pkg;

    localparam logic [3:0] OP_HLT = 4'b0000;
    localparam logic [3:0] OP_SKZ = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_LDA = 4'b0101;
    localparam logic [3:0] OP_STO = 4'b0110;
    localparam logic [3:0] OP_JMP = 4'b0111;
    localparam logic [3:0] OP_SUB = 4'b1000;
    localparam logic [3:0] OP_OR  = 4'b1001;
    localparam logic [3:0] OP_SHL = 4'b1010;
    localparam logic [3:0] OP_SHR = 4'b1011;
    localparam logic [3:0] OP_MUL = 4'b1100;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq.
// master: producer/consumer side (drives operands, out_ready); slave: the ALU.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [3:0]       opcode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu_out;
    logic             carry;
    logic             zero;
    logic             a_is_zero;

    modport master (
        output in_valid, in_a, in_b, opcode, out_ready,
        input  in_ready, out_valid, alu_out, carry, zero, a_is_zero
    );

    modport slave (
        input  in_valid, in_a, in_b, opcode, out_ready,
        output in_ready, out_valid, alu_out, carry, zero, a_is_zero
    );

endinterface

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier: i_start loads operands, then one iteration per cycle.
// Ports: clk, rst, i_start, i_a, i_b in; o_done (after WIDTH iterations), o_product out.
module alu_mul_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_product
);

    logic               r_busy;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (i_start) begin
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, i_a};
            r_mplier <= i_b;
        end else if (r_busy) begin
            // done is presented for one cycle once the count hits WIDTH
            if (r_cnt == CNT_W'(WIDTH)) begin
                r_busy <= 1'b0;
            end else begin
                if (r_mplier[0]) begin
                    r_acc <= r_acc + r_mcand;
                end
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + 1'b1;
            end
        end
    end

    assign o_done    = r_busy && (r_cnt == CNT_W'(WIDTH));
    assign o_product = r_acc;

endmodule

// File: rtl/alu_seq.sv
// Sequential accumulator ALU with a registered result slot behind valid/ready.
// Ports: clk, rst (sync, active-high), bus (alu_seq_if.slave: operands in, result/flags out).
// Macro ALU_MUL_EN: enables the multi-cycle MUL (opcode 1100) via alu_mul_seq.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic       clk,
    input  logic       rst,
    alu_seq_if.slave   bus
);

    state_t           r_state;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_alu_out;
    logic             r_carry;
    logic             r_zero;
    logic             r_a_zero;

    logic             w_in_ready;
    logic             w_accept;
    logic [WIDTH-1:0] w_res;
    logic             w_cy;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;

`ifdef ALU_MUL_EN
    logic               r_mul_a_zero;
    logic               w_mul_start;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_product;

    assign w_in_ready  = (r_state == ST_IDLE) && (!r_out_valid || bus.out_ready);
    assign w_mul_start = w_accept && (bus.opcode == OP_MUL);

    alu_mul_seq #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_mul_start),
        .i_a       (bus.in_a),
        .i_b       (bus.in_b),
        .o_done    (w_mul_done),
        .o_product (w_product)
    );
`else
    assign w_in_ready = !r_out_valid || bus.out_ready;
`endif

    assign w_accept = bus.in_valid && w_in_ready;

    // single-cycle datapath; MUL falls into the pass-A default
    always_comb begin
        w_sum  = {1'b0, bus.in_a} + {1'b0, bus.in_b};
        w_diff = {1'b0, bus.in_a} - {1'b0, bus.in_b};
        w_res  = bus.in_a;
        w_cy   = 1'b0;
        case (bus.opcode)
            OP_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_cy  = w_sum[WIDTH];
            end
            OP_AND: w_res = bus.in_a & bus.in_b;
            OP_XOR: w_res = bus.in_a ^ bus.in_b;
            OP_LDA: w_res = bus.in_b;
            OP_SUB: begin
                // top bit of the widened difference is the borrow
                w_res = w_diff[WIDTH-1:0];
                w_cy  = w_diff[WIDTH];
            end
            OP_OR:  w_res = bus.in_a | bus.in_b;
            OP_SHL: begin
                w_res = {bus.in_a[WIDTH-2:0], 1'b0};
                w_cy  = bus.in_a[WIDTH-1];
            end
            OP_SHR: begin
                w_res = {1'b0, bus.in_a[WIDTH-1:1]};
                w_cy  = bus.in_a[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_alu_out   <= '0;
            r_carry     <= 1'b0;
            r_zero      <= 1'b0;
            r_a_zero    <= 1'b0;
`ifdef ALU_MUL_EN
            r_mul_a_zero <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
`ifdef ALU_MUL_EN
                        if (bus.opcode == OP_MUL) begin
                            // slot is empty or draining this edge
                            r_state      <= ST_BUSY;
                            r_out_valid  <= 1'b0;
                            r_mul_a_zero <= (bus.in_a == '0);
                        end else
`endif
                        begin
                            r_out_valid <= 1'b1;
                            r_alu_out   <= w_res;
                            r_carry     <= w_cy;
                            r_zero      <= (w_res == '0);
                            r_a_zero    <= (bus.in_a == '0);
                        end
                    end else if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                ST_BUSY: begin
`ifdef ALU_MUL_EN
                    if (w_mul_done) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b1;
                        r_alu_out   <= w_product[WIDTH-1:0];
                        r_carry     <= |w_product[2*WIDTH-1:WIDTH];
                        r_zero      <= (w_product[WIDTH-1:0] == '0);
                        r_a_zero    <= r_mul_a_zero;
                    end
`else
                    r_state <= ST_IDLE;
`endif
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.alu_out   = r_alu_out;
    assign bus.carry     = r_carry;
    assign bus.zero      = r_zero;
    assign bus.a_is_zero = r_a_zero;

endmodule
